// File: rtl/fdivsqrt_iter_ctrl.sv
// Sequencing controller for the radix-4 divide/sqrt iteration datapath.
// Optional early termination on a zero residual is enabled by FDIVSQRT_EARLY_TERM_EN.
module fdivsqrt_iter_ctrl #(
   parameter int unsigned CYC_H = 4,
   parameter int unsigned CYC_S = 7,
   parameter int unsigned CYC_D = 14,
   parameter int unsigned CYC_Q = 29,
   parameter int unsigned CNTW  = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            Start,
   output logic            Ready,
   input  logic [1:0]      Fmt,
   input  logic            SqrtE,
   input  logic            SpecialCase,
   input  logic            WZero,
   input  logic            Flush,
   output logic            Load,
   output logic            IterEn,
   output logic            FirstIter,
   output logic            LastIter,
   output logic [CNTW-1:0] Step,
   output logic            SqrtM,
   output logic            Busy,
   output logic            Done,
   input  logic            DoneAck,
   output logic            EarlyTerm
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

   state_e          state_q, state_d;
   logic [CNTW-1:0] step_q, step_d;
   logic [CNTW-1:0] n_q, n_d;
   logic [CNTW-1:0] fmt_cyc;
   logic            sqrtm_q, sqrtm_d;
   logic            et_q, et_d;
   logic            ready_q, busy_q, done_q, iter_q, first_q, last_q;
   logic            ready_d, busy_d, done_d, iter_d, first_d, last_d;

   // Iteration count per operand format
   always_comb begin
      unique case (Fmt)
         2'b10:   fmt_cyc = CNTW'(CYC_H);
         2'b00:   fmt_cyc = CNTW'(CYC_S);
         2'b01:   fmt_cyc = CNTW'(CYC_D);
         default: fmt_cyc = CNTW'(CYC_Q);
      endcase
   end

`ifndef FDIVSQRT_EARLY_TERM_EN
   logic unused_wzero;
   assign unused_wzero = WZero;
`endif

   // Next-state and next-output decode; Flush overrides everything
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      n_d     = n_q;
      sqrtm_d = sqrtm_q;
      et_d    = et_q;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               sqrtm_d = SqrtE;
               n_d     = fmt_cyc;
               step_d  = '0;
               et_d    = 1'b0;
               state_d = SpecialCase ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (last_q) begin
               state_d = DONE;
               et_d    = 1'b0;
            end
`ifdef FDIVSQRT_EARLY_TERM_EN
            else if (!first_q && WZero) begin
               state_d = DONE;
               et_d    = 1'b1;
            end
`endif
            else begin
               step_d = step_q + CNTW'(1);
            end
         end
         DONE: begin
            if (DoneAck) begin
               state_d = IDLE;
               step_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            step_d  = '0;
         end
      endcase
      if (Flush) begin
         state_d = IDLE;
         step_d  = '0;
         et_d    = 1'b0;
         sqrtm_d = sqrtm_q;
         n_d     = n_q;
      end
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      iter_d  = (state_d == BUSY);
      first_d = (state_d == BUSY) && (step_d == '0);
      last_d  = (state_d == BUSY) && (step_d == CNTW'(n_d - CNTW'(1)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         n_q     <= '0;
         sqrtm_q <= 1'b0;
         et_q    <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         iter_q  <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         n_q     <= n_d;
         sqrtm_q <= sqrtm_d;
         et_q    <= et_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         iter_q  <= iter_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   assign Load      = Start & ready_q & ~Flush;
   assign Ready     = ready_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign IterEn    = iter_q;
   assign FirstIter = first_q;
   assign LastIter  = last_q;
   assign Step      = step_q;
   assign SqrtM     = sqrtm_q;
`ifdef FDIVSQRT_EARLY_TERM_EN
   assign EarlyTerm = et_q;
`else
   assign EarlyTerm = 1'b0;
`endif

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Directed bench for fdivsqrt_iter_ctrl; expectations follow FDIVSQRT_EARLY_TERM_EN if defined.
module tb_fdivsqrt_iter_ctrl;

   localparam int unsigned CNTW = 5;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            Start, SqrtE, SpecialCase, WZero, Flush, DoneAck;
   logic [1:0]      Fmt;
   logic            Ready, Load, IterEn, FirstIter, LastIter, SqrtM, Busy, Done, EarlyTerm;
   logic [CNTW-1:0] Step;

   int n_chk  = 0;
   int n_pass = 0;

   fdivsqrt_iter_ctrl dut (
      .clk(clk), .reset_n(reset_n), .Start(Start), .Ready(Ready), .Fmt(Fmt),
      .SqrtE(SqrtE), .SpecialCase(SpecialCase), .WZero(WZero), .Flush(Flush),
      .Load(Load), .IterEn(IterEn), .FirstIter(FirstIter), .LastIter(LastIter),
      .Step(Step), .SqrtM(SqrtM), .Busy(Busy), .Done(Done), .DoneAck(DoneAck),
      .EarlyTerm(EarlyTerm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept an operation: checks Load in the accept cycle, leaves bench at t+1
   task automatic accept(input logic [1:0] f, input logic sq, input logic sp);
      Fmt = f; SqrtE = sq; SpecialCase = sp; Start = 1'b1;
      #1;
      chk("load_at_accept", 32'(Load), 32'd1);
      tick();
      Start = 1'b0; SpecialCase = 1'b0;
   endtask

   task automatic ack();
      DoneAck = 1'b1;
      tick();
      DoneAck = 1'b0;
   endtask

   initial begin
      int iters;
      int done_seen;
      int budget;
      reset_n = 1'b0; Start = 0; SqrtE = 0; SpecialCase = 0; WZero = 0;
      Flush = 0; DoneAck = 0; Fmt = 2'b00;
      repeat (2) tick();
      chk("rst_ready", 32'(Ready), 32'd1);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_iteren", 32'(IterEn), 32'd0);
      chk("rst_step", 32'(Step), 32'd0);
      chk("rst_sqrtm", 32'(SqrtM), 32'd0);
      chk("rst_earlyterm", 32'(EarlyTerm), 32'd0);
      chk("rst_load", 32'(Load), 32'd0);
      reset_n = 1'b1;
      tick();

      // Reset in the middle of a single-precision operation
      accept(2'b00, 1'b1, 1'b0);
      repeat (3) tick();
      chk("midbusy_step", 32'(Step), 32'd3);
      reset_n = 1'b0;
      #1;
      chk("arst_ready", 32'(Ready), 32'd1);
      chk("arst_busy", 32'(Busy), 32'd0);
      chk("arst_step", 32'(Step), 32'd0);
      chk("arst_done", 32'(Done), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Double-precision divide: 14 iterations, Done held until ack
      accept(2'b01, 1'b0, 1'b0);
      for (int k = 0; k < 14; k++) begin
         chk("d_iteren", 32'(IterEn), 32'd1);
         chk("d_step", 32'(Step), 32'(k));
         chk("d_first", 32'(FirstIter), (k == 0) ? 32'd1 : 32'd0);
         chk("d_last", 32'(LastIter), (k == 13) ? 32'd1 : 32'd0);
         chk("d_done_early", 32'(Done), 32'd0);
         tick();
      end
      chk("d_iteren_off", 32'(IterEn), 32'd0);
      chk("d_sqrtm", 32'(SqrtM), 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk("d_done_hold", 32'(Done), 32'd1);
         chk("d_ready_low", 32'(Ready), 32'd0);
         tick();
      end
      ack();
      chk("d_ready_after_ack", 32'(Ready), 32'd1);
      chk("d_done_after_ack", 32'(Done), 32'd0);
      chk("d_step_after_ack", 32'(Step), 32'd0);

      // Special case half-precision sqrt: no iterations
      accept(2'b10, 1'b1, 1'b1);
      chk("sp_done", 32'(Done), 32'd1);
      chk("sp_iteren", 32'(IterEn), 32'd0);
      chk("sp_sqrtm", 32'(SqrtM), 32'd1);
      ack();
      chk("sp_ready", 32'(Ready), 32'd1);
      chk("sp_sqrtm_hold", 32'(SqrtM), 32'd1);

      // Quad precision flushed at Step 10
      accept(2'b11, 1'b0, 1'b0);
      repeat (10) tick();
      chk("q_step10", 32'(Step), 32'd10);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      chk("q_flush_ready", 32'(Ready), 32'd1);
      chk("q_flush_busy", 32'(Busy), 32'd0);
      chk("q_flush_step", 32'(Step), 32'd0);
      done_seen = 0;
      for (int k = 0; k < 30; k++) begin
         if (Done) done_seen++;
         tick();
      end
      chk("q_no_done", 32'(done_seen), 32'd0);
      Start = 1'b1; Flush = 1'b1; Fmt = 2'b01;
      #1;
      chk("sf_load", 32'(Load), 32'd0);
      tick();
      Start = 1'b0; Flush = 1'b0;
      chk("sf_ready", 32'(Ready), 32'd1);
      chk("sf_busy", 32'(Busy), 32'd0);

      // Start pulses while busy / done are ignored
      accept(2'b10, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         Start = 1'b1; Fmt = 2'b11; SqrtE = 1'b1;
         #1;
         chk("ign_load_busy", 32'(Load), 32'd0);
         chk("ign_step", 32'(Step), 32'(k));
         chk("ign_last", 32'(LastIter), (k == 3) ? 32'd1 : 32'd0);
         tick();
      end
      chk("ign_done", 32'(Done), 32'd1);
      chk("ign_sqrtm", 32'(SqrtM), 32'd0);
      tick();
      chk("ign_done_hold", 32'(Done), 32'd1);
      Start = 1'b0;
      ack();
      chk("ign_ready", 32'(Ready), 32'd1);

      // Zero residual at Step 2 of a single-precision operation
      accept(2'b00, 1'b0, 1'b0);
      iters = 0;
      budget = 40;
      while (!Done && budget > 0) begin
         WZero = (Step == 5'd2);
         if (IterEn) iters++;
         tick();
         budget--;
      end
      WZero = 1'b0;
      chk("et_timeout", 32'(Done), 32'd1);
`ifdef FDIVSQRT_EARLY_TERM_EN
      chk("et_iters", 32'(iters), 32'd3);
      chk("et_flag", 32'(EarlyTerm), 32'd1);
`else
      chk("et_iters", 32'(iters), 32'd7);
      chk("et_flag", 32'(EarlyTerm), 32'd0);
`endif
      ack();
      chk("et_ready", 32'(Ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
